// File: rtl/ct_pmp_chk_arb_if.sv
// Request, response and shared PMP-port signals of the three-requester PMP check arbiter.
interface ct_pmp_chk_arb_if;
   localparam int unsigned PA_W  = 28;
   localparam int unsigned FLG_W = 4;

   logic             req0_vld;
   logic             req1_vld;
   logic             req2_vld;
   logic [PA_W-1:0]  req0_pa;
   logic [PA_W-1:0]  req1_pa;
   logic [PA_W-1:0]  req2_pa;
   logic             req0_fetch;
   logic             req1_fetch;
   logic             req2_fetch;
   logic             arb_req0_grnt;
   logic             arb_req1_grnt;
   logic             arb_req2_grnt;
   logic             arb_rsp0_vld;
   logic             arb_rsp1_vld;
   logic             arb_rsp2_vld;
   logic [FLG_W-1:0] arb_rsp_flg;
   logic             cp0_pmp_wreg;
   logic [PA_W-1:0]  arb_pmp_pa;
   logic             arb_pmp_fetch;
   logic [FLG_W-1:0] pmp_arb_flg;

   modport master (
      output req0_vld, req1_vld, req2_vld,
      output req0_pa, req1_pa, req2_pa,
      output req0_fetch, req1_fetch, req2_fetch,
      output cp0_pmp_wreg, pmp_arb_flg,
      input  arb_req0_grnt, arb_req1_grnt, arb_req2_grnt,
      input  arb_rsp0_vld, arb_rsp1_vld, arb_rsp2_vld,
      input  arb_rsp_flg, arb_pmp_pa, arb_pmp_fetch
   );

   modport slave (
      input  req0_vld, req1_vld, req2_vld,
      input  req0_pa, req1_pa, req2_pa,
      input  req0_fetch, req1_fetch, req2_fetch,
      input  cp0_pmp_wreg, pmp_arb_flg,
      output arb_req0_grnt, arb_req1_grnt, arb_req2_grnt,
      output arb_rsp0_vld, arb_rsp1_vld, arb_rsp2_vld,
      output arb_rsp_flg, arb_pmp_pa, arb_pmp_fetch
   );
endinterface

// File: rtl/ct_pmp_chk_arb.sv
// Arbitrates three PMP check requesters onto one shared PMP port (2-cycle latency).
// Define CT_PMP_ARB_RR_EN for round-robin; fixed priority req0 > req1 > req2 otherwise.
module ct_pmp_chk_arb (
   input logic            forever_cpuclk,
   input logic            cpurst_b,
   ct_pmp_chk_arb_if.slave bus
);
   localparam int unsigned PA_W  = 28;
   localparam int unsigned FLG_W = 4;
   localparam int unsigned N_REQ = 3;

   typedef enum logic {RUN = 1'b0, FENCE = 1'b1} state_t;

   state_t             state_q;
   state_t             state_d;
   logic               grant_en_c;
   logic [N_REQ-1:0]   req_vld;
   logic [N_REQ-1:0]   sel_c;
   logic [N_REQ-1:0]   grnt_c;
   logic               grant_any_c;
   logic [1:0]         gid_c;
   logic [PA_W-1:0]    gnt_pa_c;
   logic               gnt_fetch_c;
   logic               retire_c;

   logic               s1_vld;
   logic [PA_W-1:0]    s1_pa;
   logic               s1_fetch;
   logic [1:0]         s1_id;
   logic [N_REQ-1:0]   rsp_vld_q;
   logic [FLG_W-1:0]   rsp_flg_q;

   assign req_vld = {bus.req2_vld, bus.req1_vld, bus.req0_vld};

`ifdef CT_PMP_ARB_RR_EN
   logic [1:0] rr_ptr;

   // Priority rotates so that rr_ptr names the first requester considered
   always_comb begin
      sel_c = '0;
      case (rr_ptr)
         2'd1: begin
            if      (req_vld[1]) sel_c = 3'b010;
            else if (req_vld[2]) sel_c = 3'b100;
            else if (req_vld[0]) sel_c = 3'b001;
         end
         2'd2: begin
            if      (req_vld[2]) sel_c = 3'b100;
            else if (req_vld[0]) sel_c = 3'b001;
            else if (req_vld[1]) sel_c = 3'b010;
         end
         default: begin
            if      (req_vld[0]) sel_c = 3'b001;
            else if (req_vld[1]) sel_c = 3'b010;
            else if (req_vld[2]) sel_c = 3'b100;
         end
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)        rr_ptr <= 2'd0;
      else if (grant_any_c) rr_ptr <= (gid_c == 2'd2) ? 2'd0 : 2'(gid_c + 2'd1);
   end
`else
   always_comb begin
      sel_c = '0;
      if      (req_vld[0]) sel_c = 3'b001;
      else if (req_vld[1]) sel_c = 3'b010;
      else if (req_vld[2]) sel_c = 3'b100;
   end
`endif

   // Fence state register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state_q <= RUN;
      else           state_q <= state_d;
   end

   // Grants only in RUN with no CSR write; FENCE gives the held entry one clean recheck cycle
   always_comb begin
      state_d    = state_q;
      grant_en_c = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.cp0_pmp_wreg) state_d = FENCE;
            else                  grant_en_c = 1'b1;
         end
         FENCE: begin
            if (!bus.cp0_pmp_wreg) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign grnt_c      = sel_c & {N_REQ{grant_en_c & cpurst_b}};
   assign grant_any_c = |grnt_c;
   assign retire_c    = s1_vld & ~bus.cp0_pmp_wreg;

   always_comb begin
      gid_c       = 2'd0;
      gnt_pa_c    = bus.req0_pa;
      gnt_fetch_c = bus.req0_fetch;
      if (grnt_c[1]) begin
         gid_c       = 2'd1;
         gnt_pa_c    = bus.req1_pa;
         gnt_fetch_c = bus.req1_fetch;
      end else if (grnt_c[2]) begin
         gid_c       = 2'd2;
         gnt_pa_c    = bus.req2_pa;
         gnt_fetch_c = bus.req2_fetch;
      end
   end

   // Stage 1 drives the PMP port; pa/fetch keep their value once the entry retires
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         s1_vld    <= 1'b0;
         s1_pa     <= '0;
         s1_fetch  <= 1'b0;
         s1_id     <= 2'd0;
         rsp_vld_q <= '0;
         rsp_flg_q <= '0;
      end else begin
         rsp_vld_q <= retire_c ? 3'(3'b001 << s1_id) : 3'b000;
         if (retire_c) rsp_flg_q <= bus.pmp_arb_flg;
         if (grant_any_c) begin
            s1_vld   <= 1'b1;
            s1_pa    <= gnt_pa_c;
            s1_fetch <= gnt_fetch_c;
            s1_id    <= gid_c;
         end else if (retire_c) begin
            s1_vld   <= 1'b0;
         end
      end
   end

   assign bus.arb_req0_grnt = grnt_c[0];
   assign bus.arb_req1_grnt = grnt_c[1];
   assign bus.arb_req2_grnt = grnt_c[2];
   assign bus.arb_rsp0_vld  = rsp_vld_q[0];
   assign bus.arb_rsp1_vld  = rsp_vld_q[1];
   assign bus.arb_rsp2_vld  = rsp_vld_q[2];
   assign bus.arb_rsp_flg   = rsp_flg_q;
   assign bus.arb_pmp_pa    = s1_pa;
   assign bus.arb_pmp_fetch = s1_fetch;

endmodule

// File: tb/tb_ct_pmp_chk_arb.sv
// Self-checking bench for ct_pmp_chk_arb: directed scenarios plus randomized traffic against a reference model.
module tb_ct_pmp_chk_arb;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ct_pmp_chk_arb_if bus();
   ct_pmp_chk_arb dut (.forever_cpuclk(clk), .cpurst_b(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

`ifdef CT_PMP_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   function automatic logic [2:0] grnt_vec();
      return {bus.arb_req2_grnt, bus.arb_req1_grnt, bus.arb_req0_grnt};
   endfunction

   function automatic logic [2:0] rsp_vec();
      return {bus.arb_rsp2_vld, bus.arb_rsp1_vld, bus.arb_rsp0_vld};
   endfunction

   function automatic int order_at(input int k);
      return RR ? (k % 3) : 0;
   endfunction

   task automatic set_req(input int n, input logic v, input logic [27:0] pa, input logic f);
      case (n)
         0: begin bus.req0_vld = v; bus.req0_pa = pa; bus.req0_fetch = f; end
         1: begin bus.req1_vld = v; bus.req1_pa = pa; bus.req1_fetch = f; end
         default: begin bus.req2_vld = v; bus.req2_pa = pa; bus.req2_fetch = f; end
      endcase
   endtask

   task automatic clear_inputs();
      for (int n = 0; n < 3; n++) set_req(n, 1'b0, 28'h0, 1'b0);
      bus.cp0_pmp_wreg = 1'b0;
      bus.pmp_arb_flg  = 4'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int n = 0; n < 3; n++) set_req(n, 1'b1, 28'(n + 5), 1'b1);
      bus.cp0_pmp_wreg = 1'b0;
      bus.pmp_arb_flg  = 4'hF;
      repeat (2) @(negedge clk);
      checks++; if (grnt_vec() !== 3'b000) begin errors++; $display("FAIL reset_grnt: got %b expected 000", grnt_vec()); end
      checks++; if (rsp_vec() !== 3'b000) begin errors++; $display("FAIL reset_rsp: got %b expected 000", rsp_vec()); end
      checks++; if (bus.arb_rsp_flg !== 4'h0) begin errors++; $display("FAIL reset_flg: got %h expected 0", bus.arb_rsp_flg); end
      checks++; if (bus.arb_pmp_pa !== 28'h0) begin errors++; $display("FAIL reset_pa: got %h expected 0", bus.arb_pmp_pa); end
      checks++; if (bus.arb_pmp_fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b expected 0", bus.arb_pmp_fetch); end
      next_cycle();
      clear_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 1'b1, 28'h0123456, 1'b1);
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b010) begin errors++; $display("FAIL single_grnt: got %b expected 010", grnt_vec()); end
      next_cycle();
      clear_inputs();
      bus.pmp_arb_flg = 4'hA;
      @(negedge clk);
      checks++; if (bus.arb_pmp_pa !== 28'h0123456) begin errors++; $display("FAIL single_pa: got %h expected 0123456", bus.arb_pmp_pa); end
      checks++; if (bus.arb_pmp_fetch !== 1'b1) begin errors++; $display("FAIL single_fetch: got %b expected 1", bus.arb_pmp_fetch); end
      checks++; if (rsp_vec() !== 3'b000) begin errors++; $display("FAIL single_early_rsp: got %b expected 000", rsp_vec()); end
      next_cycle();
      bus.pmp_arb_flg = 4'h3;
      @(negedge clk);
      checks++; if (rsp_vec() !== 3'b010) begin errors++; $display("FAIL single_rsp: got %b expected 010", rsp_vec()); end
      checks++; if (bus.arb_rsp_flg !== 4'hA) begin errors++; $display("FAIL single_flg: got %h expected a", bus.arb_rsp_flg); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_vec() !== 3'b000) begin errors++; $display("FAIL single_rsp_pulse: got %b expected 000", rsp_vec()); end
      checks++; if (bus.arb_rsp_flg !== 4'hA) begin errors++; $display("FAIL single_flg_hold: got %h expected a", bus.arb_rsp_flg); end
      checks++; if (bus.arb_pmp_pa !== 28'h0123456) begin errors++; $display("FAIL single_pa_hold: got %h expected 0123456", bus.arb_pmp_pa); end
      next_cycle();
   endtask

   task automatic test_all_three();
      logic [2:0]  eg;
      logic [27:0] epa;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 3; n++) set_req(n, k < 6, 28'h1000 * 28'(n + 1), n[0]);
         bus.pmp_arb_flg = 4'(k + 1);
         @(negedge clk);
         eg = (k < 6) ? 3'(1 << order_at(k)) : 3'b000;
         checks++; if (grnt_vec() !== eg) begin errors++; $display("FAIL all3_grnt[%0d]: got %b expected %b", k, grnt_vec(), eg); end
         if (k >= 1 && k <= 6) begin
            epa = 28'h1000 * 28'(order_at(k - 1) + 1);
            checks++; if (bus.arb_pmp_pa !== epa) begin errors++; $display("FAIL all3_pa[%0d]: got %h expected %h", k, bus.arb_pmp_pa, epa); end
         end
         if (k >= 2) begin
            eg = 3'(1 << order_at(k - 2));
            checks++; if (rsp_vec() !== eg) begin errors++; $display("FAIL all3_rsp[%0d]: got %b expected %b", k, rsp_vec(), eg); end
            checks++; if (bus.arb_rsp_flg !== 4'(k)) begin errors++; $display("FAIL all3_flg[%0d]: got %h expected %h", k, bus.arb_rsp_flg, 4'(k)); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_fence();
      do_reset();
      set_req(2, 1'b1, 28'h0ABCDEF, 1'b0);
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b100) begin errors++; $display("FAIL fence_grnt: got %b expected 100", grnt_vec()); end
      next_cycle();
      clear_inputs();
      set_req(0, 1'b1, 28'h0000111, 1'b1);
      bus.cp0_pmp_wreg = 1'b1;
      bus.pmp_arb_flg  = 4'h1;
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b000) begin errors++; $display("FAIL fence_wreg_grnt: got %b expected 000", grnt_vec()); end
      next_cycle();
      bus.cp0_pmp_wreg = 1'b0;
      bus.pmp_arb_flg  = 4'h8;
      @(negedge clk);
      checks++; if (rsp_vec() !== 3'b000) begin errors++; $display("FAIL fence_no_rsp: got %b expected 000", rsp_vec()); end
      checks++; if (grnt_vec() !== 3'b000) begin errors++; $display("FAIL fence_state_grnt: got %b expected 000", grnt_vec()); end
      checks++; if (bus.arb_pmp_pa !== 28'h0ABCDEF) begin errors++; $display("FAIL fence_held_pa: got %h expected 0abcdef", bus.arb_pmp_pa); end
      next_cycle();
      bus.pmp_arb_flg = 4'h2;
      @(negedge clk);
      checks++; if (rsp_vec() !== 3'b100) begin errors++; $display("FAIL fence_rsp: got %b expected 100", rsp_vec()); end
      checks++; if (bus.arb_rsp_flg !== 4'h8) begin errors++; $display("FAIL fence_flg: got %h expected 8", bus.arb_rsp_flg); end
      checks++; if (grnt_vec() !== 3'b001) begin errors++; $display("FAIL fence_resume_grnt: got %b expected 001", grnt_vec()); end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_wreg_hold();
      int grants;
      do_reset();
      grants = 0;
      set_req(0, 1'b1, 28'h0000777, 1'b0);
      bus.cp0_pmp_wreg = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.cp0_pmp_wreg = 1'b0;
         @(negedge clk);
         if (grnt_vec() !== 3'b000) grants++;
         next_cycle();
      end
      checks++; if (grants !== 0) begin errors++; $display("FAIL wreg_hold_grants: got %0d expected 0", grants); end
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b001) begin errors++; $display("FAIL wreg_hold_resume: got %b expected 001", grnt_vec()); end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      set_req(1, 1'b1, 28'h0FFFFFF, 1'b1);
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b010) begin errors++; $display("FAIL midrst_grnt: got %b expected 010", grnt_vec()); end
      next_cycle();
      clear_inputs();
      bus.pmp_arb_flg = 4'h5;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.arb_pmp_pa !== 28'h0) begin errors++; $display("FAIL midrst_pa: got %h expected 0", bus.arb_pmp_pa); end
      checks++; if (bus.arb_pmp_fetch !== 1'b0) begin errors++; $display("FAIL midrst_fetch: got %b expected 0", bus.arb_pmp_fetch); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_vec() !== 3'b000) begin errors++; $display("FAIL midrst_rsp: got %b expected 000", rsp_vec()); end
      checks++; if (bus.arb_rsp_flg !== 4'h0) begin errors++; $display("FAIL midrst_flg: got %h expected 0", bus.arb_rsp_flg); end
      next_cycle();
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) set_req(n, 1'b1, 28'(n + 1), 1'b0);
      @(negedge clk);
      checks++; if (grnt_vec() !== 3'b001) begin errors++; $display("FAIL midrst_first_grnt: got %b expected 001", grnt_vec()); end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   // Reference model: pending check (at most one) plus a pointer kept as a plain integer mod 3
   task automatic test_random(input int ncyc, input int wreg_pct);
      bit          v[3];
      logic [27:0] pa[3];
      bit          f[3];
      bit          wreg;
      logic [3:0]  flg;
      int          ptr, g, id, n;
      bit          pend, fence, ret;
      logic [27:0] m_pa;
      bit          m_fetch;
      logic [2:0]  m_rsp, eg;
      logic [3:0]  m_flg;
      do_reset();
      ptr = 0; pend = 0; fence = 0; id = 0;
      m_pa = '0; m_fetch = 0; m_rsp = '0; m_flg = '0;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 3; i++) begin
            v[i]  = ($urandom_range(1) == 1);
            pa[i] = 28'($urandom);
            f[i]  = ($urandom_range(1) == 1);
            set_req(i, v[i], pa[i], f[i]);
         end
         wreg = ($urandom_range(99) < wreg_pct);
         flg  = 4'($urandom);
         bus.cp0_pmp_wreg = wreg;
         bus.pmp_arb_flg  = flg;
         @(negedge clk);
         g = -1;
         if (!fence && !wreg)
            for (int i = 0; i < 3; i++) begin
               n = RR ? (ptr + i) % 3 : i;
               if (g < 0 && v[n]) g = n;
            end
         eg = (g < 0) ? 3'b000 : 3'(1 << g);
         checks++; if (grnt_vec() !== eg) begin errors++; $display("FAIL rnd_grnt[%0d]: got %b expected %b", c, grnt_vec(), eg); end
         checks++; if (bus.arb_pmp_pa !== m_pa) begin errors++; $display("FAIL rnd_pa[%0d]: got %h expected %h", c, bus.arb_pmp_pa, m_pa); end
         checks++; if (bus.arb_pmp_fetch !== m_fetch) begin errors++; $display("FAIL rnd_fetch[%0d]: got %b expected %b", c, bus.arb_pmp_fetch, m_fetch); end
         checks++; if (rsp_vec() !== m_rsp) begin errors++; $display("FAIL rnd_rsp[%0d]: got %b expected %b", c, rsp_vec(), m_rsp); end
         checks++; if (bus.arb_rsp_flg !== m_flg) begin errors++; $display("FAIL rnd_flg[%0d]: got %h expected %h", c, bus.arb_rsp_flg, m_flg); end
         ret   = pend && !wreg;
         m_rsp = ret ? 3'(1 << id) : 3'b000;
         if (ret) m_flg = flg;
         if (g >= 0) begin
            pend = 1; id = g; m_pa = pa[g]; m_fetch = f[g];
            ptr = (g + 1) % 3;
         end else if (ret) begin
            pend = 0;
         end
         fence = wreg;
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_all_three();
      test_fence();
      test_wreg_hold();
      test_reset_midflight();
      test_random(400, 15);
      test_random(200, 50);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ct_pmp_chk_arb.md
CT_PMP_CHK_ARB -- requirements
Module: ct_pmp_chk_arb

Interface
REQ-001 SHALL have ports: forever_cpuclk  in  1  sole clock.
REQ-002 SHALL have ports: cpurst_b  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: reqN_vld  in  1  check request from requester N (N = 0, 1, 2).
REQ-004 SHALL have ports: reqN_pa  in  28  physical page address to check (N = 0..2).
REQ-005 SHALL have ports: reqN_fetch  in  1  request is an instruction fetch (N = 0..2).
REQ-006 SHALL have ports: arb_reqN_grnt  out  1  request N accepted this cycle (N = 0..2).
REQ-007 SHALL have ports: arb_rspN_vld  out  1  one-cycle result pulse for requester N (N = 0..2).
REQ-008 SHALL have ports: arb_rsp_flg  out  4  PMP flag result, shared by all requesters.
REQ-009 SHALL have ports: cp0_pmp_wreg  in  1  PMP CSR write in progress this cycle.
REQ-010 SHALL have ports: arb_pmp_pa  out  28  address driven to the shared PMP check port.
REQ-011 SHALL have ports: arb_pmp_fetch  out  1  fetch qualifier to the shared PMP check port.
REQ-012 SHALL have ports: pmp_arb_flg  in  4  combinational PMP flag result for arb_pmp_pa.
REQ-013 SHALL use one clock, forever_cpuclk; reset cpurst_b SHALL be asynchronous and active-low.

Function
REQ-014 SHALL grant at most one request per cycle: arb_reqN_grnt = reqN_vld & selected & state==RUN. The grant is combinational.
REQ-015 Requester SHALL hold vld, pa and fetch stable until granted; the block SHALL NOT depend on this for correctness beyond the grant cycle.
REQ-016 Grant cycle T SHALL load stage-1 registers (s1_vld, s1_pa, s1_fetch, s1_id[1:0]).
- arb_pmp_pa = s1_pa and arb_pmp_fetch = s1_fetch during T+1.
REQ-017 At the end of T+1, SHALL capture pmp_arb_flg into arb_rsp_flg and pulse arb_rsp{s1_id}_vld in T+2.
- Latency is 2 cycles.
- Throughput is 1 check per cycle.
- There is no response backpressure.
REQ-018 When s1_vld=0, arb_pmp_pa and arb_pmp_fetch SHALL hold their last values.
- arb_rsp_flg SHALL hold its last value when no response pulses.
REQ-019 FSM states SHALL be RUN and FENCE.
- RUN->FENCE when cp0_pmp_wreg=1.
- FENCE->RUN when cp0_pmp_wreg=0.
- FENCE->FENCE while cp0_pmp_wreg=1.
REQ-020 While cp0_pmp_wreg=1 (in either state), SHALL issue no grant.
- A valid stage-1 entry SHALL NOT retire; it SHALL be held so that it is rechecked against the updated configuration.
REQ-021 In FENCE with cp0_pmp_wreg=0, the held entry SHALL retire (response the next cycle) and grants SHALL stay blocked.
- Grants resume in the following RUN cycle.
REQ-022 Arbitration order SHALL be as defined in REQ-026/REQ-027.
- A simultaneous request from all three requesters SHALL yield exactly one grant.
REQ-023 A request arriving in the same cycle as cp0_pmp_wreg SHALL NOT be granted.

Reset
REQ-024 On reset assertion, SHALL immediately clear:
- state=RUN
- s1_vld=0
- s1_pa=0, s1_fetch=0, s1_id=0
- arb_rsp_flg=0
- all arb_rspN_vld=0
- round-robin pointer=0
Any in-flight check SHALL be dropped with no response. All grants SHALL be 0 while reset is asserted.
REQ-025 First grant is possible in the first clock edge cycle after reset deassertion.

Configuration
REQ-026 With CT_PMP_ARB_RR_EN defined: round-robin arbitration.
- 2-bit pointer names the highest-priority requester.
- After a grant to N, the pointer moves to (N+1) mod 3.
- The pointer is unchanged when there is no grant.
REQ-027 With CT_PMP_ARB_RR_EN undefined: fixed priority req0 > req1 > req2; the pointer register SHALL be absent.

Verification
REQ-028 Single req1_vld, pa=28'h0123456, fetch=1 at T -> grnt1 at T; arb_pmp_pa=28'h0123456 and arb_pmp_fetch=1 at T+1; rsp1_vld with flg=pmp_arb_flg sampled at T+1 at T+2.
REQ-029 All three reqs held for 6 cycles (RR_EN) -> grant order 0,1,2,0,1,2; responses 2 cycles after each grant. With the macro undefined -> six consecutive grants to 0.
REQ-030 Grant at T, cp0_pmp_wreg=1 at T+1 with flg=4'h1 -> no response at T+2; FENCE at T+2 with flg=4'h8 -> rsp at T+3 carrying 4'h8; no grant until T+3.
REQ-031 cp0_pmp_wreg high for 3 consecutive cycles while req0 is held -> zero grants during those cycles and the FENCE cycle; req0 granted on the first RUN cycle after.
REQ-032 cpurst_b low between grant and response -> no rsp pulse; all outputs 0; pointer back to 0; first request after release granted normally.
